// File: rtl/word_capture_fifo.sv
// word_capture_fifo: first-word-fall-through capture buffer between the
// byte packer and the host transfer stage. The write side never stalls;
// words arriving while the buffer is full are dropped, counted and flagged.
// Optional build macro OVF_MARKER_EN: after a run of drops, insert a marker
// word {16'hDEAD, pending drop count} at the first free slot so the host
// can see where the gap in the captured stream is.
module word_capture_fifo #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                tb_clock,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] out_data,
    input  logic                out_ready,
    input  logic                clr_ovf,
    output logic [ADDR_W:0]     level,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_LEN-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_LEN-1:0] out_data_q, out_data_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                full_w;
    logic                empty_w;
    logic                do_write;
    logic                do_read;
    logic                drop;
    logic [DATA_LEN-1:0] write_word;

`ifdef OVF_MARKER_EN
    logic [CNT_W-1:0]    pend_q, pend_d;
    logic                marker_now;
    logic [15:0]         pend_lo;
    logic [31:0]         marker_raw;
`endif

    // Occupancy flags come straight from the pointer pair; the extra wrap bit
    // separates full from empty when the index bits match.
    always_comb begin
        full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        empty_w = (wr_ptr_q == rd_ptr_q);
    end

    // Decide what gets written this cycle, what is dropped, and whether the
    // head word is consumed. Full is judged on start-of-cycle occupancy, so a
    // read in the same cycle never makes room for a write.
    always_comb begin
        do_read    = !empty_w && out_ready;
        write_word = in_data;
`ifdef OVF_MARKER_EN
        pend_lo    = 16'(pend_q);
        marker_raw = {16'hDEAD, pend_lo};
        marker_now = (pend_q != '0) && !full_w;
        if (marker_now) begin
            write_word = DATA_LEN'(marker_raw);
        end
        do_write   = !full_w && (in_valid || marker_now);
        drop       = in_valid && (full_w || marker_now);
`else
        do_write   = !full_w && in_valid;
        drop       = in_valid && full_w;
`endif
    end

    // Next pointers and the registered head word. When the slot being written
    // becomes the head after this edge, the incoming word is forwarded so the
    // head register is correct one cycle after the write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_write && (rd_ptr_d == wr_ptr_q)) begin
            out_data_d = write_word;
        end else begin
            out_data_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
        end
    end

    // Loss bookkeeping: a drop in the same cycle as a clear leaves the flag set
    // and the counter at one, so that loss is never hidden from the host.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

`ifdef OVF_MARKER_EN
    // Drops pending a marker; writing the marker restarts the count, with a
    // word lost in the marker cycle itself becoming the first of the next run.
    always_comb begin
        pend_d = pend_q;
        if (marker_now) begin
            pend_d = in_valid ? CNT_W'(1) : '0;
        end else if (drop && (pend_q != {CNT_W{1'b1}})) begin
            pend_d = pend_q + 1'b1;
        end
    end

    // Pending-drop register.
    always_ff @(posedge tb_clock) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    // Control and status state; reset empties the buffer but leaves storage.
    always_ff @(posedge tb_clock) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array, written only outside reset.
    always_ff @(posedge tb_clock) begin
        if (rst_n && do_write) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= write_word;
        end
    end

    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign out_valid = !empty_w;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_word_capture_fifo.sv
// tb_word_capture_fifo: directed bench for word_capture_fifo (default depth 16).
// Inputs change 1 ns after each rising edge and outputs are sampled there.
module tb_word_capture_fifo;

    logic        tb_clock;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        clr_ovf;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    word_capture_fifo #(
        .DATA_LEN(32),
        .ADDR_W  (4),
        .CNT_W   (16)
    ) dut (
        .tb_clock (tb_clock),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .clr_ovf  (clr_ovf),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    // 100 MHz clock.
    initial begin
        tb_clock = 1'b0;
        forever #5 tb_clock = ~tb_clock;
    end

    // Advance one clock and land 1 ns past the edge.
    task automatic tick();
        @(posedge tb_clock);
        #1;
    endtask

    // Drive one cycle of write-side and read-side inputs, then clock.
    task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                  input logic rdy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
        tick();
    endtask

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();

        // Reset state, with in_valid held high during reset.
        check_output("rst_level", 32'(level), 32'd0);
        check_output("rst_empty", 32'(empty), 32'd1);
        check_output("rst_full", 32'(full), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Five writes with the consumer stalled.
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 1) begin
                check_output("first_word_valid", 32'(out_valid), 32'd1);
                check_output("first_word_data", out_data, 32'd1);
            end
        end
        in_valid = 1'b0;
        check_output("fill5_level", 32'(level), 32'd5);
        check_output("fill5_empty", 32'(empty), 32'd0);

        // Drain them in order.
        for (int k = 1; k <= 5; k++) begin
            check_output("drain5_data", out_data, 32'(k));
            apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check_output("drain5_empty", 32'(empty), 32'd1);
        check_output("drain5_out_valid", 32'(out_valid), 32'd0);

        // Read while empty leaves everything unchanged.
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        check_output("empty_read_level", 32'(level), 32'd0);

        // Streaming across several pointer wraps: each word is the head one
        // cycle after it is written and occupancy stays at one.
        for (int i = 0; i < 44; i++) begin
            apply_stimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
            check_output("stream_valid", 32'(out_valid), 32'd1);
            check_output("stream_data", out_data, 32'h100 + 32'(i));
            check_output("stream_level", 32'(level), 32'd1);
        end
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        check_output("stream_end_empty", 32'(empty), 32'd1);

`ifndef OVF_MARKER_EN
        // Twenty writes into a 16-deep buffer: four are dropped.
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            if (i == 16) begin
                check_output("fill16_full", 32'(full), 32'd1);
                check_output("fill16_level", 32'(level), 32'd16);
                check_output("fill16_overflow", 32'(overflow), 32'd0);
            end
        end
        check_output("ovf_flag", 32'(overflow), 32'd1);
        check_output("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
        check_output("ovf_head", out_data, 32'h201);

        // Write and read together while full: read happens, write drops.
        apply_stimulus(1'b1, 32'h0BAD, 1'b1, 1'b0);
        check_output("full_rw_level", 32'(level), 32'd15);
        check_output("full_rw_drop_cnt", 32'(drop_cnt), 32'd5);
        check_output("full_rw_full", 32'(full), 32'd0);

        // Remaining stored words come back unchanged.
        for (int k = 2; k <= 16; k++) begin
            check_output("ovf_readback", out_data, 32'h200 + 32'(k));
            apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check_output("ovf_readback_empty", 32'(empty), 32'd1);

        // Clear with no drop.
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
        check_output("clr_overflow", 32'(overflow), 32'd0);
        check_output("clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Clear coincident with a drop: the drop wins.
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, 32'h3FF, 1'b0, 1'b1);
        check_output("clr_drop_overflow", 32'(overflow), 32'd1);
        check_output("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        apply_stimulus(1'b1, 32'h3FE, 1'b0, 1'b0);
        check_output("post_clr_drop_cnt", 32'(drop_cnt), 32'd2);
        check_output("post_clr_head", out_data, 32'h301);
`else
        // Fill, drop three, free one slot; the marker then takes that slot.
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h2F0 + 32'(i), 1'b0, 1'b0);
        end
        check_output("mk_drop_cnt", 32'(drop_cnt), 32'd3);
        check_output("mk_overflow", 32'(overflow), 32'd1);
        check_output("mk_head1", out_data, 32'h201);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        check_output("mk_after_read_level", 32'(level), 32'd15);
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
        check_output("mk_written_level", 32'(level), 32'd16);
        check_output("mk_drop_cnt_hold", 32'(drop_cnt), 32'd3);
        for (int k = 2; k <= 16; k++) begin
            check_output("mk_readback", out_data, 32'h200 + 32'(k));
            apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check_output("mk_marker_word", out_data, 32'hDEAD_0003);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
        check_output("mk_end_empty", 32'(empty), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        end
`endif

        // Reset in the middle of a burst discards everything.
        in_valid = 1'b1;
        in_data  = 32'h4444;
        rst_n    = 1'b0;
        tick();
        check_output("midrst_level", 32'(level), 32'd0);
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_overflow", 32'(overflow), 32'd0);
        check_output("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 32'h5555, 1'b0, 1'b0);
        check_output("postrst_level", 32'(level), 32'd1);
        check_output("postrst_data", out_data, 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
